// File: rtl/rvfi_dual_retire_emitter_if.sv
// ---------------------------------------------------------------------------
// rvfi_dual_retire_emitter_if
//
// Purpose: bundles the retirement-side handshake and the RVFI trace outputs
// of rvfi_dual_retire_emitter so that the core side and the trace consumer
// can connect through one port.
//
// Signals:
//   ret0_valid / ret0_rec   slot 0 retirement record (312-bit packed layout)
//   ret1_valid / ret1_rec   slot 1 retirement record, younger than slot 0
//   ret_ready               emitter can take two records this cycle
//   fifo_level              current buffer occupancy
//   proto_err               sticky protocol-violation flag
//   rvfi_*                  standard 32-bit RVFI packet outputs
//
// Modports:
//   slave   the emitter itself
//   master  the core/testbench that drives retirements and observes rvfi_*
// ---------------------------------------------------------------------------
interface rvfi_dual_retire_emitter_if #(
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic               ret0_valid;
    logic [311:0]       ret0_rec;
    logic               ret1_valid;
    logic [311:0]       ret1_rec;
    logic               ret_ready;
    logic [LW-1:0]      fifo_level;
    logic               proto_err;

    logic               rvfi_valid;
    logic [ORDER_W-1:0] rvfi_order;
    logic [31:0]        rvfi_insn;
    logic [31:0]        rvfi_pc_rdata;
    logic [31:0]        rvfi_pc_wdata;
    logic [31:0]        rvfi_rs1_rdata;
    logic [31:0]        rvfi_rs2_rdata;
    logic [31:0]        rvfi_rd_wdata;
    logic [31:0]        rvfi_mem_addr;
    logic [31:0]        rvfi_mem_rdata;
    logic [31:0]        rvfi_mem_wdata;
    logic [4:0]         rvfi_rs1_addr;
    logic [4:0]         rvfi_rs2_addr;
    logic [4:0]         rvfi_rd_addr;
    logic [3:0]         rvfi_mem_rmask;
    logic [3:0]         rvfi_mem_wmask;
    logic               rvfi_trap;

    modport slave (
        input  ret0_valid, ret0_rec, ret1_valid, ret1_rec,
        output ret_ready, fifo_level, proto_err,
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
        output rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr,
        output rvfi_mem_rdata, rvfi_mem_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
        output rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_trap
    );

    modport master (
        output ret0_valid, ret0_rec, ret1_valid, ret1_rec,
        input  ret_ready, fifo_level, proto_err,
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
        input  rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr,
        input  rvfi_mem_rdata, rvfi_mem_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
        input  rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_trap
    );
endinterface

// File: rtl/rvfi_dual_retire_emitter.sv
// ---------------------------------------------------------------------------
// rvfi_dual_retire_emitter
//
// Purpose: producer side of the RVFI trace channel. Buffers up to two
// in-order retirement records per cycle in a FIFO and emits one RVFI packet
// per cycle with a monotonically increasing (wrapping) rvfi_order.
//
// Ports:
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     rvfi_dual_retire_emitter_if.slave (retire handshake + rvfi_*)
//
// Parameters:
//   DEPTH    FIFO entries (power of two, >= 4)
//   ORDER_W  width of rvfi_order
// ---------------------------------------------------------------------------
module rvfi_dual_retire_emitter #(
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 8
) (
    input  logic                         clock,
    input  logic                         resetn,
    rvfi_dual_retire_emitter_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

    typedef struct packed {
        logic        trap;
        logic [3:0]  mem_wmask;
        logic [3:0]  mem_rmask;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic [31:0] mem_addr;
        logic [31:0] rd_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rs2_rdata;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [4:0]  rs1_addr;
        logic [31:0] pc_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] insn;
    } rec_t;

    rec_t               mem [DEPTH];
    rec_t               head;
    rec_t               out_q;
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        level;
    logic [AW-1:0]      wr_idx0;
    logic [AW-1:0]      wr_idx1;
    logic               empty;
    logic               full;
    logic               ready;
    logic               proto_viol;
    logic               push0;
    logic               push1;
    logic               valid_q;
    logic               err_q;
    logic [ORDER_W-1:0] order_q;
    logic [ORDER_W-1:0] order_cnt;

    // Pointers carry an extra wrap bit: equal pointers mean empty, equal
    // indices with differing wrap bits mean full.
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Ready depends only on registered occupancy so the core never sees a
    // combinational path from its own valids back to ready.
    assign ready = !full && (level <= READY_MAX);

    // A violating cycle drops both slots so the trace never holds a partial pair.
    assign proto_viol = ((bus.ret0_valid || bus.ret1_valid) && !ready) ||
                        (bus.ret1_valid && !bus.ret0_valid);
    assign push0   = bus.ret0_valid && !proto_viol;
    assign push1   = push0 && bus.ret1_valid;
    assign wr_idx0 = wr_ptr[AW-1:0];
    assign wr_idx1 = wr_idx0 + 1'b1;

    // The head slot never collides with a write slot because pushes need
    // at least two free entries.
    always_ff @(posedge clock) begin
        if (push0) mem[wr_idx0] <= bus.ret0_rec;
        if (push1) mem[wr_idx1] <= bus.ret1_rec;
    end

    // RVFI requires rd_wdata to read zero whenever the destination is x0.
    always_comb begin
        head = mem[rd_ptr[AW-1:0]];
        if (head.rd_addr == 5'd0) head.rd_wdata = '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            order_q   <= '0;
            order_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + {{AW{1'b0}}, push0} + {{AW{1'b0}}, push1};
            valid_q <= !empty;
            if (!empty) begin
                rd_ptr    <= rd_ptr + 1'b1;
                out_q     <= head;
                order_q   <= order_cnt;
                order_cnt <= order_cnt + 1'b1;
            end
            if (proto_viol) err_q <= 1'b1;
        end
    end

    assign bus.ret_ready      = ready;
    assign bus.fifo_level     = level;
    assign bus.proto_err      = err_q;
    assign bus.rvfi_valid     = valid_q;
    assign bus.rvfi_order     = order_q;
    assign bus.rvfi_insn      = out_q.insn;
    assign bus.rvfi_pc_rdata  = out_q.pc_rdata;
    assign bus.rvfi_pc_wdata  = out_q.pc_wdata;
    assign bus.rvfi_rs1_addr  = out_q.rs1_addr;
    assign bus.rvfi_rs1_rdata = out_q.rs1_rdata;
    assign bus.rvfi_rs2_addr  = out_q.rs2_addr;
    assign bus.rvfi_rs2_rdata = out_q.rs2_rdata;
    assign bus.rvfi_rd_addr   = out_q.rd_addr;
    assign bus.rvfi_rd_wdata  = out_q.rd_wdata;
    assign bus.rvfi_mem_addr  = out_q.mem_addr;
    assign bus.rvfi_mem_rdata = out_q.mem_rdata;
    assign bus.rvfi_mem_wdata = out_q.mem_wdata;
    assign bus.rvfi_mem_rmask = out_q.mem_rmask;
    assign bus.rvfi_mem_wmask = out_q.mem_wmask;
    assign bus.rvfi_trap      = out_q.trap;
endmodule

// File: tb/tb_rvfi_dual_retire_emitter.sv
// ---------------------------------------------------------------------------
// tb_rvfi_dual_retire_emitter
//
// Purpose: directed self-checking bench for rvfi_dual_retire_emitter.
// Drives retirement records through the interface and compares rvfi_*,
// fifo_level, ret_ready and proto_err against hand-computed values.
// ---------------------------------------------------------------------------
module tb_rvfi_dual_retire_emitter;
    logic clock;
    logic resetn;
    int   checks;
    int   fails;

    rvfi_dual_retire_emitter_if #(.DEPTH(8), .ORDER_W(8)) bus ();

    rvfi_dual_retire_emitter #(.DEPTH(8), .ORDER_W(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record builder: everything except pc, rd_addr and rd_wdata is derived
    // from insn so each field of a packet is distinguishable.
    function automatic logic [311:0] mk_rec(input logic [31:0] insn, input logic [31:0] pc,
                                            input logic [4:0] rd_addr, input logic [31:0] rd_wdata);
        logic [31:0] rdata;
        rdata = insn * 32'd3;
        return {insn[0], insn[7:4], insn[3:0], insn ^ 32'hFFFF0000, rdata,
                insn ^ 32'hA5A5A5A5, rd_wdata, rd_addr, ~insn, insn[9:5],
                insn ^ 32'h11111111, insn[4:0], pc + 32'd4, pc, insn};
    endfunction

    task automatic idle_inputs();
        bus.ret0_valid = 1'b0;
        bus.ret1_valid = 1'b0;
        bus.ret0_rec   = '0;
        bus.ret1_rec   = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        checks++; if (bus.rvfi_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %0b exp 0", bus.rvfi_valid); end
        checks++; if (bus.rvfi_order !== 8'd0) begin fails++; $display("[TB] FAIL reset_order got %0d exp 0", bus.rvfi_order); end
        checks++; if (bus.rvfi_insn !== 32'd0) begin fails++; $display("[TB] FAIL reset_insn got %h exp 0", bus.rvfi_insn); end
        checks++; if (bus.fifo_level !== 4'd0) begin fails++; $display("[TB] FAIL reset_level got %0d exp 0", bus.fifo_level); end
        checks++; if (bus.ret_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got %0b exp 1", bus.ret_ready); end
        checks++; if (bus.proto_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_proto_err got %0b exp 0", bus.proto_err); end
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.ret0_valid = 1'b1;
        bus.ret0_rec   = mk_rec(32'h00000013, 32'h0, 5'd0, 32'h0);
        tick();
        idle_inputs();
        checks++; if (bus.fifo_level !== 4'd1) begin fails++; $display("[TB] FAIL single_level1 got %0d exp 1", bus.fifo_level); end
        checks++; if (bus.rvfi_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_no_bypass got %0b exp 0", bus.rvfi_valid); end
        tick();
        checks++; if (bus.rvfi_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_valid got %0b exp 1", bus.rvfi_valid); end
        checks++; if (bus.rvfi_order !== 8'd0) begin fails++; $display("[TB] FAIL single_order got %0d exp 0", bus.rvfi_order); end
        checks++; if (bus.rvfi_insn !== 32'h00000013) begin fails++; $display("[TB] FAIL single_insn got %h exp 00000013", bus.rvfi_insn); end
        checks++; if (bus.rvfi_pc_rdata !== 32'h0) begin fails++; $display("[TB] FAIL single_pc_rdata got %h exp 0", bus.rvfi_pc_rdata); end
        checks++; if (bus.rvfi_pc_wdata !== 32'h4) begin fails++; $display("[TB] FAIL single_pc_wdata got %h exp 4", bus.rvfi_pc_wdata); end
        checks++; if (bus.rvfi_rs1_addr !== 5'h13) begin fails++; $display("[TB] FAIL single_rs1_addr got %h exp 13", bus.rvfi_rs1_addr); end
        checks++; if (bus.rvfi_rs1_rdata !== 32'h11111102) begin fails++; $display("[TB] FAIL single_rs1_rdata got %h exp 11111102", bus.rvfi_rs1_rdata); end
        checks++; if (bus.rvfi_rs2_addr !== 5'h0) begin fails++; $display("[TB] FAIL single_rs2_addr got %h exp 0", bus.rvfi_rs2_addr); end
        checks++; if (bus.rvfi_rs2_rdata !== 32'hFFFFFFEC) begin fails++; $display("[TB] FAIL single_rs2_rdata got %h exp ffffffec", bus.rvfi_rs2_rdata); end
        checks++; if (bus.rvfi_rd_addr !== 5'h0) begin fails++; $display("[TB] FAIL single_rd_addr got %h exp 0", bus.rvfi_rd_addr); end
        checks++; if (bus.rvfi_mem_addr !== 32'hA5A5A5B6) begin fails++; $display("[TB] FAIL single_mem_addr got %h exp a5a5a5b6", bus.rvfi_mem_addr); end
        checks++; if (bus.rvfi_mem_rdata !== 32'h39) begin fails++; $display("[TB] FAIL single_mem_rdata got %h exp 39", bus.rvfi_mem_rdata); end
        checks++; if (bus.rvfi_mem_wdata !== 32'hFFFF0013) begin fails++; $display("[TB] FAIL single_mem_wdata got %h exp ffff0013", bus.rvfi_mem_wdata); end
        checks++; if (bus.rvfi_mem_rmask !== 4'h3) begin fails++; $display("[TB] FAIL single_rmask got %h exp 3", bus.rvfi_mem_rmask); end
        checks++; if (bus.rvfi_mem_wmask !== 4'h1) begin fails++; $display("[TB] FAIL single_wmask got %h exp 1", bus.rvfi_mem_wmask); end
        checks++; if (bus.rvfi_trap !== 1'b1) begin fails++; $display("[TB] FAIL single_trap got %0b exp 1", bus.rvfi_trap); end
        checks++; if (bus.fifo_level !== 4'd0) begin fails++; $display("[TB] FAIL single_level0 got %0d exp 0", bus.fifo_level); end
        tick();
        checks++; if (bus.rvfi_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_valid_off got %0b exp 0", bus.rvfi_valid); end
        checks++; if (bus.rvfi_insn !== 32'h00000013) begin fails++; $display("[TB] FAIL single_insn_hold got %h exp 00000013", bus.rvfi_insn); end
    endtask

    // Dual push whenever the bench's own level model says ready; the
    // scoreboard queue holds record ids in expected emission order.
    task automatic test_back_to_back();
        int q[$];
        int lvl;
        int next_id;
        int emitted;
        int npush;
        int id;
        bit exp_ready;
        bit pop;
        bit saw_not_ready;
        do_reset();
        lvl = 0; next_id = 0; emitted = 0; saw_not_ready = 0;
        for (int c = 0; c < 40; c++) begin
            exp_ready = ((8 - lvl) >= 2);
            if (!exp_ready) saw_not_ready = 1;
            checks++; if (bus.ret_ready !== exp_ready) begin fails++; $display("[TB] FAIL b2b_ready cycle %0d got %0b exp %0b", c, bus.ret_ready, exp_ready); end
            npush = 0;
            if (c < 24 && exp_ready) begin
                bus.ret0_valid = 1'b1;
                bus.ret0_rec   = mk_rec(32'h10000000 + next_id, next_id * 4, 5'(next_id) | 5'd1, 32'h30000000 + next_id);
                bus.ret1_valid = 1'b1;
                bus.ret1_rec   = mk_rec(32'h10000000 + next_id + 1, (next_id + 1) * 4, 5'(next_id + 1) | 5'd1, 32'h30000000 + next_id + 1);
                npush = 2;
            end
            tick();
            idle_inputs();
            pop = (lvl > 0);
            checks++; if (bus.rvfi_valid !== pop) begin fails++; $display("[TB] FAIL b2b_valid cycle %0d got %0b exp %0b", c, bus.rvfi_valid, pop); end
            if (pop) begin
                id = q.pop_front();
                checks++; if (bus.rvfi_insn !== 32'h10000000 + id) begin fails++; $display("[TB] FAIL b2b_insn got %h exp %h", bus.rvfi_insn, 32'h10000000 + id); end
                checks++; if (bus.rvfi_rd_wdata !== 32'h30000000 + id) begin fails++; $display("[TB] FAIL b2b_rd_wdata got %h exp %h", bus.rvfi_rd_wdata, 32'h30000000 + id); end
                checks++; if (bus.rvfi_order !== 8'(emitted)) begin fails++; $display("[TB] FAIL b2b_order got %0d exp %0d", bus.rvfi_order, emitted % 256); end
                emitted++;
            end
            if (npush == 2) begin
                q.push_back(next_id);
                q.push_back(next_id + 1);
                next_id += 2;
            end
            lvl = lvl + npush - (pop ? 1 : 0);
            checks++; if (bus.fifo_level !== 4'(lvl)) begin fails++; $display("[TB] FAIL b2b_level cycle %0d got %0d exp %0d", c, bus.fifo_level, lvl); end
        end
        if (!saw_not_ready) $display("[TB] note: back-to-back run never reached a full level");
    endtask

    task automatic test_proto_err();
        do_reset();
        bus.ret1_valid = 1'b1;
        bus.ret1_rec   = mk_rec(32'hBAD00001, 32'h100, 5'd2, 32'h1);
        tick();
        idle_inputs();
        checks++; if (bus.proto_err !== 1'b1) begin fails++; $display("[TB] FAIL proto_slot1_only got %0b exp 1", bus.proto_err); end
        checks++; if (bus.fifo_level !== 4'd0) begin fails++; $display("[TB] FAIL proto_slot1_level got %0d exp 0", bus.fifo_level); end
        tick();
        checks++; if (bus.rvfi_valid !== 1'b0) begin fails++; $display("[TB] FAIL proto_slot1_no_packet got %0b exp 0", bus.rvfi_valid); end
        checks++; if (bus.proto_err !== 1'b1) begin fails++; $display("[TB] FAIL proto_sticky got %0b exp 1", bus.proto_err); end

        do_reset();
        checks++; if (bus.proto_err !== 1'b0) begin fails++; $display("[TB] FAIL proto_reset_clear got %0b exp 0", bus.proto_err); end
        for (int c = 0; c < 6; c++) begin
            bus.ret0_valid = 1'b1;
            bus.ret0_rec   = mk_rec(32'h40000000 + 2 * c, 32'h0, 5'd1, 32'h0);
            bus.ret1_valid = 1'b1;
            bus.ret1_rec   = mk_rec(32'h40000000 + 2 * c + 1, 32'h0, 5'd1, 32'h0);
            tick();
        end
        idle_inputs();
        checks++; if (bus.fifo_level !== 4'd7) begin fails++; $display("[TB] FAIL proto_fill_level got %0d exp 7", bus.fifo_level); end
        checks++; if (bus.ret_ready !== 1'b0) begin fails++; $display("[TB] FAIL proto_fill_ready got %0b exp 0", bus.ret_ready); end
        checks++; if (bus.proto_err !== 1'b0) begin fails++; $display("[TB] FAIL proto_fill_err got %0b exp 0", bus.proto_err); end
        bus.ret0_valid = 1'b1;
        bus.ret0_rec   = mk_rec(32'hBAD00002, 32'h0, 5'd1, 32'h0);
        tick();
        idle_inputs();
        checks++; if (bus.proto_err !== 1'b1) begin fails++; $display("[TB] FAIL proto_not_ready got %0b exp 1", bus.proto_err); end
        checks++; if (bus.fifo_level !== 4'd6) begin fails++; $display("[TB] FAIL proto_not_ready_level got %0d exp 6", bus.fifo_level); end
        checks++; if (bus.rvfi_insn !== 32'h40000005) begin fails++; $display("[TB] FAIL proto_head_insn got %h exp 40000005", bus.rvfi_insn); end
        checks++; if (bus.rvfi_order !== 8'd5) begin fails++; $display("[TB] FAIL proto_head_order got %0d exp 5", bus.rvfi_order); end
        for (int k = 6; k < 12; k++) begin
            tick();
            checks++; if (bus.rvfi_valid !== 1'b1) begin fails++; $display("[TB] FAIL proto_drain_valid got %0b exp 1", bus.rvfi_valid); end
            checks++; if (bus.rvfi_insn !== 32'h40000000 + k) begin fails++; $display("[TB] FAIL proto_drain_insn got %h exp %h", bus.rvfi_insn, 32'h40000000 + k); end
        end
        tick();
        checks++; if (bus.rvfi_valid !== 1'b0) begin fails++; $display("[TB] FAIL proto_dropped_not_emitted got %0b exp 0", bus.rvfi_valid); end
    endtask

    task automatic test_rd_zero();
        do_reset();
        bus.ret0_valid = 1'b1;
        bus.ret0_rec   = mk_rec(32'h00000033, 32'h200, 5'd0, 32'hDEADBEEF);
        bus.ret1_valid = 1'b1;
        bus.ret1_rec   = mk_rec(32'h00000093, 32'h204, 5'd5, 32'h12345678);
        tick();
        idle_inputs();
        tick();
        checks++; if (bus.rvfi_rd_wdata !== 32'h0) begin fails++; $display("[TB] FAIL rdzero_wdata got %h exp 0", bus.rvfi_rd_wdata); end
        checks++; if (bus.rvfi_rd_addr !== 5'd0) begin fails++; $display("[TB] FAIL rdzero_addr got %0d exp 0", bus.rvfi_rd_addr); end
        tick();
        checks++; if (bus.rvfi_rd_wdata !== 32'h12345678) begin fails++; $display("[TB] FAIL rdnonzero_wdata got %h exp 12345678", bus.rvfi_rd_wdata); end
        checks++; if (bus.rvfi_rd_addr !== 5'd5) begin fails++; $display("[TB] FAIL rdnonzero_addr got %0d exp 5", bus.rvfi_rd_addr); end
    endtask

    task automatic test_order_wrap();
        do_reset();
        for (int e = 0; e <= 260; e++) begin
            if (e < 260) begin
                bus.ret0_valid = 1'b1;
                bus.ret0_rec   = mk_rec(32'h20000000 + e, 32'h0, 5'd1, 32'h0);
            end else begin
                idle_inputs();
            end
            tick();
            if (e >= 1) begin
                checks++; if (bus.rvfi_valid !== 1'b1) begin fails++; $display("[TB] FAIL wrap_valid packet %0d got %0b exp 1", e - 1, bus.rvfi_valid); end
                checks++; if (bus.rvfi_order !== 8'((e - 1) % 256)) begin fails++; $display("[TB] FAIL wrap_order packet %0d got %0d exp %0d", e - 1, bus.rvfi_order, (e - 1) % 256); end
                checks++; if (bus.rvfi_insn !== 32'h20000000 + e - 1) begin fails++; $display("[TB] FAIL wrap_insn got %h exp %h", bus.rvfi_insn, 32'h20000000 + e - 1); end
            end
        end
        idle_inputs();
        tick();
        checks++; if (bus.rvfi_valid !== 1'b0) begin fails++; $display("[TB] FAIL wrap_end_valid got %0b exp 0", bus.rvfi_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            bus.ret0_valid = 1'b1;
            bus.ret0_rec   = mk_rec(32'h50000000 + 2 * c, 32'h40, 5'd3, 32'h7);
            bus.ret1_valid = 1'b1;
            bus.ret1_rec   = mk_rec(32'h50000000 + 2 * c + 1, 32'h44, 5'd3, 32'h7);
            tick();
        end
        idle_inputs();
        checks++; if (bus.fifo_level !== 4'd5) begin fails++; $display("[TB] FAIL mid_level_before got %0d exp 5", bus.fifo_level); end
        resetn = 1'b0;
        #1;
        checks++; if (bus.rvfi_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_valid got %0b exp 0", bus.rvfi_valid); end
        checks++; if (bus.rvfi_insn !== 32'h0) begin fails++; $display("[TB] FAIL mid_insn got %h exp 0", bus.rvfi_insn); end
        checks++; if (bus.rvfi_order !== 8'd0) begin fails++; $display("[TB] FAIL mid_order got %0d exp 0", bus.rvfi_order); end
        checks++; if (bus.rvfi_pc_rdata !== 32'h0) begin fails++; $display("[TB] FAIL mid_pc got %h exp 0", bus.rvfi_pc_rdata); end
        checks++; if (bus.rvfi_rd_wdata !== 32'h0) begin fails++; $display("[TB] FAIL mid_rd_wdata got %h exp 0", bus.rvfi_rd_wdata); end
        checks++; if (bus.rvfi_mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL mid_mem_addr got %h exp 0", bus.rvfi_mem_addr); end
        checks++; if (bus.fifo_level !== 4'd0) begin fails++; $display("[TB] FAIL mid_level got %0d exp 0", bus.fifo_level); end
        checks++; if (bus.ret_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_ready got %0b exp 1", bus.ret_ready); end
        tick();
        resetn = 1'b1;
        bus.ret0_valid = 1'b1;
        bus.ret0_rec   = mk_rec(32'h00000077, 32'h80, 5'd3, 32'h9);
        tick();
        idle_inputs();
        checks++; if (bus.fifo_level !== 4'd1) begin fails++; $display("[TB] FAIL mid_after_level got %0d exp 1", bus.fifo_level); end
        tick();
        checks++; if (bus.rvfi_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_after_valid got %0b exp 1", bus.rvfi_valid); end
        checks++; if (bus.rvfi_order !== 8'd0) begin fails++; $display("[TB] FAIL mid_after_order got %0d exp 0", bus.rvfi_order); end
        checks++; if (bus.rvfi_insn !== 32'h00000077) begin fails++; $display("[TB] FAIL mid_after_insn got %h exp 00000077", bus.rvfi_insn); end
        tick();
        checks++; if (bus.rvfi_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_discarded got %0b exp 0", bus.rvfi_valid); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_proto_err();
        test_rd_zero();
        test_order_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
